// File: rtl/clkdiv_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_prog
//  Purpose  : Bank of NUM_CH programmable clock-enable dividers sharing one
//             clock. Each channel produces a square wave (clk_out) and a
//             one-cycle tick at the start of every period. New divisors are
//             staged in a shadow register and only take effect at a period
//             boundary, so a period is never cut short or stretched by a write.
//
//  Ports    : clk       - single clock, all logic on the rising edge
//             reset     - synchronous, active-high reset
//             ena       - global run; 0 freezes every channel
//             sync_all  - strobe restarting all channels at phase 0
//             div_in    - divisor value for writes
//             div_wr    - per-channel write strobe for div_in
//             clk_out   - per-channel divided square wave (registered)
//             tick      - per-channel period-start pulse (registered)
//             pending   - per-channel staged divisor not yet applied
//
//  Revision : 1.0 - initial release
// ============================================================================
module clkdiv_prog #(
    parameter int NUM_CH      = 2,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              sync_all,
    input  logic [WIDTH-1:0]  div_in,
    input  logic [NUM_CH-1:0] div_wr,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [WIDTH:0]   c_ONE_X   = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] c_DEFAULT = WIDTH'(DEFAULT_DIV);

    // After reset every channel sits at k=0 with its outputs low. The first
    // running edge (or a sync) begins the first period at k=0 rather than
    // advancing past it, so the first tick is not lost.
    logic started_q;
    logic started_d;

    assign started_d = started_q | ena | sync_all;

    always_ff @(posedge clk) begin
        if (reset) begin
            started_q <= 1'b0;
        end else begin
            started_q <= started_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] k_q;
        logic [WIDTH-1:0] k_d;
        logic [WIDTH-1:0] div_q;
        logic [WIDTH-1:0] div_d;
        logic [WIDTH-1:0] shadow_q;
        logic [WIDTH-1:0] shadow_d;
        logic             pend_q;
        logic             pend_d;
        logic             clk_q;
        logic             clk_d;
        logic             tick_q;
        logic             tick_d;

        logic             w_apply;   // edge where a staged divisor may load
        logic [WIDTH:0]   w_half;    // ceil(D/2), one extra bit for D=2^W-1
        logic             w_level;

        always_comb begin
            k_d     = k_q;
            w_apply = 1'b0;

            if (sync_all) begin
                k_d     = '0;
                w_apply = 1'b1;
            end else if (div_q == '0) begin
                // Stopped channel: no period to wait for, load as soon as
                // something is staged.
                k_d     = '0;
                w_apply = pend_q;
            end else if (ena) begin
                if (!started_q || (k_q == div_q - c_ONE)) begin
                    k_d     = '0;
                    w_apply = 1'b1;
                end else begin
                    k_d = k_q + c_ONE;
                end
            end

            div_d    = (w_apply && pend_q) ? shadow_q : div_q;
            // A write on the apply edge is staged after the old shadow has
            // been consumed, so it lands at the following boundary.
            shadow_d = div_wr[i] ? div_in : shadow_q;
            pend_d   = div_wr[i] | (pend_q & ~w_apply);

            // Outputs are decoded from next state and registered, so they
            // line up with k in the cycle it is held.
            w_half  = ({1'b0, div_d} + c_ONE_X) >> 1;
            w_level = (div_d != '0) && ({1'b0, k_d} < w_half);
            clk_d   = (ena || w_apply) ? w_level : clk_q;
            tick_d  = ena && (div_d != '0) && (k_d == '0);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                k_q      <= '0;
                div_q    <= c_DEFAULT;
                shadow_q <= c_DEFAULT;
                pend_q   <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                k_q      <= k_d;
                div_q    <= div_d;
                shadow_q <= shadow_d;
                pend_q   <= pend_d;
                clk_q    <= clk_d;
                tick_q   <= tick_d;
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pend_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clkdiv_prog
//  Purpose  : Self-checking bench for clkdiv_prog (2 channels, 8-bit divisors).
//             Expected outputs for each cycle are queued when the stimulus is
//             driven and compared one cycle later, after the clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv_prog;

    localparam int NUM_CH = 2;
    localparam int WIDTH  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              ena;
    logic              sync_all;
    logic [WIDTH-1:0]  div_in;
    logic [NUM_CH-1:0] div_wr;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    always #5 clk = ~clk;

    clkdiv_prog #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ena      (ena),
        .sync_all (sync_all),
        .div_in   (div_in),
        .div_wr   (div_wr),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
    );

    // Inputs for one edge and the outputs expected after it ({ch1,ch0}).
    typedef struct {
        logic       rst;
        logic       en;
        logic       syn;
        logic [7:0] din;
        logic [1:0] wr;
        logic [1:0] eclk;
        logic [1:0] etick;
        logic [1:0] epend;
    } vec_t;

    vec_t       tbl[$];
    logic [5:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         step_no  = 0;

    function automatic vec_t mk(input logic r, input logic e, input logic s,
                                input logic [7:0] d, input logic [1:0] w,
                                input logic [1:0] c, input logic [1:0] t,
                                input logic [1:0] p);
        vec_t v;
        v.rst = r; v.en = e; v.syn = s; v.din = d; v.wr = w;
        v.eclk = c; v.etick = t; v.epend = p;
        return v;
    endfunction

    task automatic step(input logic r, input logic e, input logic s,
                        input logic [7:0] d, input logic [1:0] w,
                        input logic [1:0] c, input logic [1:0] t,
                        input logic [1:0] p, input string tag);
        logic [5:0] ex;
        reset    = r;
        ena      = e;
        sync_all = s;
        div_in   = d;
        div_wr   = w;
        exp_q.push_back({c, t, p});
        @(posedge clk);
        #1;
        ex = exp_q.pop_front();
        n_checks++;
        if ({clk_out, tick, pending} !== ex) begin
            n_fail++;
            $display("FAIL %s step %0d: clk_out=%b tick=%b pending=%b, expected clk_out=%b tick=%b pending=%b",
                     tag, step_no, clk_out, tick, pending, ex[5:4], ex[3:2], ex[1:0]);
        end
        step_no++;
    endtask

    initial begin
        reset    = 1'b1;
        ena      = 1'b0;
        sync_all = 1'b0;
        div_in   = '0;
        div_wr   = '0;

        //            rst  en   syn  din wr     clk    tick   pend
        // reset, writes during reset ignored, release -> divide-by-2
        tbl.push_back(mk(1, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 1, 0, 8'd7, 2'b11, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b11, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b11, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b11, 2'b00));
        // ch0 := 5 mid-period, applied at boundary; high 3 low 2
        tbl.push_back(mk(0, 1, 0, 8'd5, 2'b01, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b11, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b10, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b10, 2'b10, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b01, 2'b01, 2'b00));
        // ch1 := 0 on its boundary edge: staged, stops at next boundary
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b10, 2'b11, 2'b10, 2'b10));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b01, 2'b00, 2'b10));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00));
        // ch1 := 3 while stopped: loads on the next edge, period 3
        tbl.push_back(mk(0, 1, 0, 8'd3, 2'b10, 2'b01, 2'b01, 2'b10));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b10, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b00, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b10, 2'b10, 2'b00));
        // ch0 writes 4 (on boundary), 6, 4: only the last lands
        tbl.push_back(mk(0, 1, 0, 8'd4, 2'b01, 2'b11, 2'b01, 2'b01));
        tbl.push_back(mk(0, 1, 0, 8'd6, 2'b01, 2'b01, 2'b00, 2'b01));
        tbl.push_back(mk(0, 1, 0, 8'd4, 2'b01, 2'b11, 2'b10, 2'b01));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b10, 2'b00, 2'b01));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b11, 2'b00));
        // ch1 := 6 staged, then sync_all with a coincident ch0 write
        tbl.push_back(mk(0, 1, 0, 8'd6, 2'b10, 2'b11, 2'b00, 2'b10));
        tbl.push_back(mk(0, 1, 1, 8'd4, 2'b01, 2'b11, 2'b11, 2'b01));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].syn, tbl[i].din, tbl[i].wr,
                 tbl[i].eclk, tbl[i].etick, tbl[i].epend, "table");
        end

        // After sync: ch0 D=4, ch1 D=6 in phase, ticks coincide every 12.
        for (int n = 1; n <= 24; n++) begin
            step(0, 1, 0, 8'd0, 2'b00,
                 {((n % 6) < 3), ((n % 4) < 2)},
                 {((n % 6) == 0), ((n % 4) == 0)},
                 {1'b0, (n < 4)}, "sync_phase");
        end

        // ch0 := 5 applied by a sync taken with ena=0, then freeze at k=2.
        step(0, 1, 0, 8'd5, 2'b01, 2'b11, 2'b00, 2'b01, "ena_hold");
        step(0, 0, 1, 8'd0, 2'b00, 2'b11, 2'b00, 2'b00, "ena_hold");
        step(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b00, 2'b00, "ena_hold");
        step(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b00, 2'b00, "ena_hold");
        for (int n = 0; n < 7; n++) begin
            step(0, 0, 0, 8'd0, 2'b00, 2'b11, 2'b00, 2'b00, "ena_hold");
        end
        step(0, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00, "ena_hold");
        step(0, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00, "ena_hold");
        step(0, 1, 0, 8'd0, 2'b00, 2'b01, 2'b01, 2'b00, "ena_hold");
        step(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b10, 2'b00, "ena_hold");

        // Reset with a staged write discards it and restores divide-by-2.
        step(0, 1, 0, 8'd9, 2'b10, 2'b11, 2'b00, 2'b10, "reset_pend");
        step(1, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00, "reset_pend");
        step(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b11, 2'b00, "reset_pend");
        step(0, 1, 0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00, "reset_pend");
        step(0, 1, 0, 8'd0, 2'b00, 2'b11, 2'b11, 2'b00, "reset_pend");

        // ch0 := 255 (max divisor), ch1 := 1 (tick every cycle).
        step(0, 1, 0, 8'd255, 2'b01, 2'b00, 2'b00, 2'b01, "div255");
        step(0, 1, 0, 8'd1,   2'b10, 2'b11, 2'b11, 2'b10, "div255");
        step(0, 1, 0, 8'd0,   2'b00, 2'b01, 2'b00, 2'b10, "div255");
        step(0, 1, 0, 8'd0,   2'b00, 2'b11, 2'b10, 2'b00, "div255");
        for (int m = 3; m < 3 + 2 * 255; m++) begin
            step(0, 1, 0, 8'd0, 2'b00,
                 {1'b1, ((m % 255) < 128)},
                 {1'b1, ((m % 255) == 0)},
                 2'b00, "div255");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
